// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
// Time-shares one enable/ready adder/subtractor between two requesters
// (port 0 = ALU, port 1 = address/PC unit). The winning requester's operands
// are captured at grant. The adder is enabled until it reports ready or the
// wait times out. The sum and carry are then returned with a one-cycle done
// pulse to the served port.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/a0/b0/sub0/done0   requester port 0 (req held until done0)
//   req1/a1/b1/sub1/done1   requester port 1 (req held until done1)
//   add_en/add_a/add_b/add_cin            drive to the shared adder
//   add_out/add_cout/add_ready            response from the shared adder
//   result, carry, err      latched completion data, held until next completion
//   busy                    high while an operation is in ISSUE or DONE
//   grant                   port currently or last served
module adder_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    output logic             done0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic             done1,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout,
    input  logic             add_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic             busy,
    output logic             grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Last ISSUE cycle index: the wait counter starts at 0 on the first
    // ISSUE cycle, so add_en stays high for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             sel;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        result_d  = result_q;
        carry_d   = carry_q;
        err_d     = err_q;
        sel       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the priority pointer (the port not
                    // served last); a lone request always wins.
                    sel       = (req0 && req1) ? prio_q : req1;
                    grant_d   = sel;
                    add_a_d   = sel ? a1 : a0;
                    add_b_d   = sel ? b1 : b0;
                    add_cin_d = sel ? sub1 : sub0;
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (add_ready) begin
                    result_d = add_out;
                    carry_d  = add_cout;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                prio_d  = ~grant_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        add_en = (state_q == S_ISSUE);
        busy   = (state_q == S_ISSUE) || (state_q == S_DONE);
        done0  = (state_q == S_DONE) && !grant_q;
        done1  = (state_q == S_DONE) &&  grant_q;
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign result  = result_q;
    assign carry   = carry_q;
    assign err     = err_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;
    localparam int W  = 16;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         done0, done1, add_en, add_cin, add_cout, add_ready;
    logic         carry, err, busy, grant;
    logic [W-1:0] add_a, add_b, add_out, result;

    int n_checks = 0;
    int n_fail   = 0;

    // Shared adder model: ready after lat_cfg cycles of add_en, never if 'never'.
    int mcnt    = 0;
    int lat_cfg = 2;
    bit never   = 1'b0;
    logic [W:0] sum_full;

    always #5 clk = ~clk;
    always @(posedge clk) mcnt <= add_en ? mcnt + 1 : 0;
    assign sum_full  = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {{W{1'b0}}, add_cin};
    assign add_out   = sum_full[W-1:0];
    assign add_cout  = sum_full[W];
    assign add_ready = add_en && !never && (mcnt >= lat_cfg);

    adder_share_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0), .done0(done0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1), .done1(done1),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_out(add_out), .add_cout(add_cout), .add_ready(add_ready),
        .result(result), .carry(carry), .err(err), .busy(busy), .grant(grant)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sub;
        int           lat;
        logic [W-1:0] exp_res;
        bit           exp_c;
    } vec_t;

    task automatic run_op(input string nm, input bit p, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit s, input int lat,
                          input logic [W-1:0] er, input bit ec, input bit ee,
                          input int exp_en);
        int n;
        int en_cyc;
        lat_cfg = lat;
        @(negedge clk);
        if (p) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
        n = 0;
        while (!add_en && n < 10) begin @(negedge clk); n++; end
        chk({nm, "_en"}, 32'(add_en), 32'd1);
        chk({nm, "_add_a"}, 32'(add_a), 32'(a));
        chk({nm, "_add_b"}, 32'(add_b), 32'(b));
        chk({nm, "_cin"}, 32'(add_cin), 32'(s));
        chk({nm, "_grant"}, 32'(grant), 32'(p));
        en_cyc = 0;
        n = 0;
        while (!(done0 || done1) && n < 300) begin
            if (add_en) en_cyc++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_p"}, 32'(p ? done1 : done0), 32'd1);
        chk({nm, "_done_other"}, 32'(p ? done0 : done1), 32'd0);
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_carry"}, 32'(carry), 32'(ec));
        chk({nm, "_err"}, 32'(err), 32'(ee));
        chk({nm, "_en_cycles"}, 32'(en_cyc), 32'(exp_en));
        chk({nm, "_en_in_done"}, 32'(add_en), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk({nm, "_done_once"}, 32'(done0 | done1), 32'd0);
        chk({nm, "_held"}, 32'(result), 32'(er));
    endtask

    initial begin
        vec_t vecs[5];
        int n;
        int gap;
        vecs[0] = '{1'b0, 16'h1234, 16'h0FF0, 1'b0, 2, 16'h2224, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 2, 16'hFFFE, 1'b0};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 16'h00FF, 16'hFF01, 1'b0, 1, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 5, 16'h7FFF, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_add_en", 32'(add_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'({done0, done1}), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_err_carry", 32'({err, carry}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].lat, vecs[i].exp_res, vecs[i].exp_c, 1'b0, vecs[i].lat + 1);

        // Reset while ISSUE is in progress
        lat_cfg = 10;
        @(negedge clk);
        req1 = 1'b1; a1 = 16'h4321; b1 = 16'h1111; sub1 = 1'b1;
        n = 0;
        while (!add_en && n < 10) begin @(negedge clk); n++; end
        chk("mid_en_before", 32'(add_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_add_en", 32'(add_en), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'({done0, done1}), 0);
        chk("mid_result", 32'(result), 0);
        chk("mid_grant", 32'(grant), 0);
        chk("mid_add_a_cin", 32'({add_a, add_cin}), 0);
        chk("mid_err_carry", 32'({err, carry}), 0);
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        repeat (4) begin @(negedge clk); if (done0 || done1 || add_en) gap++; end
        chk("mid_no_done_after", 32'(gap), 0);

        // Both requests held from reset: round-robin 0,1,0,1
        lat_cfg = 1;
        @(negedge clk);
        a0 = 16'h0010; b0 = 16'h0001; sub0 = 1'b0;
        a1 = 16'h0020; b1 = 16'h0002; sub1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(done0 || done1) && n < 50) begin @(negedge clk); n++; end
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(k % 2));
            chk($sformatf("rr%0d_done0", k), 32'(done0), 32'(k % 2 == 0));
            chk($sformatf("rr%0d_done1", k), 32'(done1), 32'(k % 2 == 1));
            chk($sformatf("rr%0d_result", k), 32'(result), (k % 2) ? 32'h001E : 32'h0011);
            if (k < 3) begin
                gap = 0;
                n = 0;
                while (!add_en && n < 20) begin gap++; @(negedge clk); n++; end
                chk($sformatf("rr%0d_gap_ge2", k), 32'(gap >= 2 && add_en), 32'd1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Adder never ready: timeout error completion, then a clean one
        never = 1'b1;
        run_op("tmo", 1'b0, 16'h0001, 16'h0001, 1'b0, 0, 16'h0000, 1'b0, 1'b1, TO);
        never = 1'b0;
        run_op("after_tmo", 1'b0, 16'h0003, 16'h0004, 1'b0, 2, 16'h0007, 1'b0, 1'b0, 3);

        // Request dropped and operands changed right after grant
        lat_cfg = 3;
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0011; sub0 = 1'b0;
        n = 0;
        while (!add_en && n < 10) begin @(negedge clk); n++; end
        req0 = 1'b0; a0 = 16'hFFFF; b0 = 16'hFFFF; sub0 = 1'b1;
        @(negedge clk);
        chk("drop_add_a", 32'(add_a), 32'h0100);
        chk("drop_cin", 32'(add_cin), 0);
        n = 0;
        while (!(done0 || done1) && n < 50) begin @(negedge clk); n++; end
        chk("drop_done0", 32'(done0), 1);
        chk("drop_result", 32'(result), 32'h0111);
        chk("drop_carry", 32'(carry), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
